// File: rtl/sreg_out_pkg.sv
// Shared definitions for the MCU readback shifter: state encoding, debug
// field layout and default geometry.
package sreg_out_pkg;

    localparam int unsigned DWIDTH_DEF  = 8;
    localparam int unsigned RD_WAIT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        SHIFT   = 2'd2,
        ADVANCE = 2'd3
    } state_t;

    // debug = {state[1:0], ready, out, bitcnt[3:0]}
    localparam int unsigned DBG_STATE_HI  = 7;
    localparam int unsigned DBG_STATE_LO  = 6;
    localparam int unsigned DBG_READY     = 5;
    localparam int unsigned DBG_OUT       = 4;
    localparam int unsigned DBG_BITCNT_HI = 3;
    localparam int unsigned DBG_BITCNT_LO = 0;

    function automatic logic [7:0] pack_debug(input state_t st, input logic rdy,
                                              input logic o, input logic [3:0] bc);
        logic [7:0] d;
        d = '0;
        d[DBG_STATE_HI:DBG_STATE_LO]   = st;
        d[DBG_READY]                   = rdy;
        d[DBG_OUT]                     = o;
        d[DBG_BITCNT_HI:DBG_BITCNT_LO] = bc;
        return d;
    endfunction

endpackage

// File: rtl/sreg_out.sv
// Parallel-to-serial SRAM readback shifter for the MCU link: enables the SRAM,
// captures a word after a fixed wait, shifts it out MSB-first, optionally streams.
module sreg_out
    import sreg_out_pkg::*;
#(
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned RD_WAIT = RD_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_n,
    input  logic              en_n,
    input  logic [DWIDTH-1:0] din,
    output logic              out,
    output logic              ready,
    output logic              sram_oe_n,
    output logic              inc_n,
    output logic [7:0]        debug
);

    localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);
    // A 16-bit word loads 0 here; the 4-bit count wraps 0->15 on the first
    // shift, so the 1->0 last-bit detection still sees exactly DWIDTH shifts.
    localparam logic [3:0] BITS_LOAD = 4'(DWIDTH);

    state_t            state, state_d;
    logic [DWIDTH-1:0] buffer, buffer_d;
    logic [3:0]        bitcnt, bitcnt_d;
    logic [3:0]        waitcnt, waitcnt_d;
    logic              ready_d;
    logic              oe_n_d;
    logic              inc_n_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buffer    <= '0;
            bitcnt    <= '0;
            waitcnt   <= '0;
            ready     <= 1'b0;
            sram_oe_n <= 1'b1;
            inc_n     <= 1'b1;
        end else begin
            state     <= state_d;
            buffer    <= buffer_d;
            bitcnt    <= bitcnt_d;
            waitcnt   <= waitcnt_d;
            ready     <= ready_d;
            sram_oe_n <= oe_n_d;
            inc_n     <= inc_n_d;
        end
    end

    always_comb begin
        state_d   = state;
        buffer_d  = buffer;
        bitcnt_d  = bitcnt;
        waitcnt_d = waitcnt;
        ready_d   = ready;
        oe_n_d    = sram_oe_n;
        inc_n_d   = inc_n;

        case (state)
            IDLE: begin
                if (!rd_n) begin
                    state_d   = ACCESS;
                    oe_n_d    = 1'b0;
                    waitcnt_d = WAIT_LOAD;
                end
            end

            ACCESS: begin
                oe_n_d = 1'b0;
                if (waitcnt != 4'd0) begin
                    waitcnt_d = waitcnt - 4'd1;
                end else begin
                    buffer_d = din;
                    bitcnt_d = BITS_LOAD;
                    oe_n_d   = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                if (!en_n) begin
                    buffer_d = {buffer[DWIDTH-2:0], 1'b0};
                    bitcnt_d = bitcnt - 4'd1;
                    // rd_n is only looked at here, so a mid-word release never aborts
                    if (bitcnt == 4'd1) begin
                        ready_d = 1'b0;
                        if (!rd_n) begin
                            state_d = ADVANCE;
                            inc_n_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            ADVANCE: begin
                inc_n_d   = 1'b1;
                oe_n_d    = 1'b0;
                waitcnt_d = WAIT_LOAD;
                state_d   = ACCESS;
            end

            default: state_d = IDLE;
        endcase
    end

    assign out   = buffer[DWIDTH-1];
    assign debug = pack_debug(state, ready, out, bitcnt);

endmodule

// File: doc/sreg_out.md
# sreg_out

Parallel-to-serial readback shifter for the CPLD's MCU link: the transmit-side counterpart of the serial address shift register. On an MCU read request it enables the SRAM outputs, captures the data word after a fixed access wait, and shifts it out MSB-first, one bit per enabled clock. In streaming mode it pulses the address register's increment strobe after each word and fetches the next word automatically, so the MCU can read consecutive SRAM locations without reloading the address.

## Interface
- `DWIDTH`, 8: SRAM data word width, in bits (2..16).
- `RD_WAIT`, 2: number of clocks `sram_oe_n` is held low before the data word is captured (1..15).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `rd_n` in 1: read/stream request, active low, level-sensitive.
- `en_n` in 1: shift enable, active low; one bit is consumed per clock while low.
- `din` in `DWIDTH`: SRAM data bus.
- `out` out 1: serial data, MSB first, registered.
- `ready` out 1: high while a captured word is being shifted.
- `sram_oe_n` out 1: SRAM output enable, active low, registered.
- `inc_n` out 1: address increment strobe, active low, one clock wide; drives the address register's `counter_n`.
- `debug` out 8: {state[1:0], ready, out, bitcnt[3:0]}.

## Operation
- Internal state: `state` (IDLE, ACCESS, SHIFT, ADVANCE); `buffer[DWIDTH-1:0]`; `bitcnt`, 4 bits; `waitcnt`, 4 bits.
- Reset values: state IDLE; buffer 0; bitcnt 0; waitcnt 0; out 0; ready 0; sram_oe_n 1; inc_n 1.
- IDLE:
  - If `rd_n` is 0: go to ACCESS, set sram_oe_n to 0, and load waitcnt with RD_WAIT-1.
  - `en_n` is ignored.
- ACCESS:
  - sram_oe_n stays 0.
  - While waitcnt is not 0, decrement it.
  - When waitcnt is 0: set buffer to din, set bitcnt to DWIDTH, set sram_oe_n to 1, set ready to 1, and go to SHIFT.
  - `out` always equals buffer[DWIDTH-1], so the first bit is valid in the same cycle that ready rises.
- SHIFT, on each clock with `en_n` = 0:
  - buffer shifts left by one, with 0 filled in at the LSB.
  - bitcnt decrements by one.
- SHIFT, on the clock that takes bitcnt from 1 to 0 (last bit consumed):
  - ready goes to 0.
  - If `rd_n` is 0: go to ADVANCE and set inc_n to 0.
  - Otherwise: go to IDLE.
- SHIFT with `en_n` = 1: hold everything.
- ADVANCE (exactly one cycle): set inc_n back to 1, set sram_oe_n to 0, load waitcnt with RD_WAIT-1, and go to ACCESS.
- `rd_n` is sampled only in IDLE and on the last-bit clock. Deasserting it mid-word does not abort the word; only `rst_n` aborts.
- `rst_n` asserted mid-operation: all registers return to their reset values immediately. sram_oe_n and inc_n go high asynchronously.
- After the last bit, out is 0 (zero-filled) until the next capture.

## Timing
- rd_n is sampled low at edge E. sram_oe_n is low from E through E+RD_WAIT, when the capture happens.
- ready and the MSB are valid after E+RD_WAIT. Read latency: RD_WAIT+1 edges from the request edge to the first bit.
- Bit k (k = 0 being the MSB) is on `out` after the k-th enabled shift edge.
- Last enabled shift at edge L, streaming:
  - inc_n is low for the single cycle L..L+1.
  - sram_oe_n is low from L+1.
  - The next capture is at L+1+RD_WAIT.
- The address register increments on the edge at L+1, so SRAM sees the new address for at least RD_WAIT cycles before capture.
- inc_n and sram_oe_n are never low in the same cycle.

## Structure
- The shared package holds:
  - the state encoding constants (IDLE=0, ACCESS=1, SHIFT=2, ADVANCE=3);
  - the 8-bit debug field layout;
  - the DWIDTH and RD_WAIT defaults.
- No sub-module is needed: a single FSM with a datapath. Top-level integration wires `inc_n` to the address register's `counter_n`.

## Test plan
- Reset values: hold rst_n=0 -> out=0, ready=0, sram_oe_n=1, inc_n=1, debug=8'h00.
- Single read, DWIDTH=8, RD_WAIT=2, din=8'hA5:
  - rd_n low for one cycle -> sram_oe_n low for 2 cycles, then ready=1.
  - With en_n held low, out yields 1,0,1,0,0,1,0,1 over 8 clocks -> then ready=0, state IDLE, inc_n never low.
- Gapped shifting: din=8'h81 with en_n toggling every other cycle -> out changes only on enabled edges; sequence 1,0,0,0,0,0,0,1.
- Streaming:
  - rd_n held low, din=8'h3C for the first word and 8'hC3 for the second.
  - Required: one-cycle inc_n pulse right after bit 8, then a new capture RD_WAIT+1 clocks later; the 16 bits received equal 3C then C3.
- Reset mid-shift: assert rst_n after 3 bits -> all outputs go to reset values immediately; a new request completes a full, correct word.
- Boundary: RD_WAIT=1 with DWIDTH=16, din=16'hFFFF -> capture one edge after request; 16 ones, then out=0.
